// File: rtl/pulse_scheduler_pkg.sv
// Shared state encoding and default configuration for the pulse scheduler.
package pulse_sched_pkg;

    localparam int unsigned DEFAULT_NUM_REQ = 4;
    localparam int unsigned DEFAULT_WIDTH_W = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PROGRAM   = 3'd1,
        ST_FIRE      = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_WAIT_LOW  = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/pulse_scheduler_if.sv
// Requester and pulse-extender signals of the pulse scheduler, grouped as one bundle.
interface pulse_scheduler_if #(
    parameter int unsigned NUM_REQ = pulse_sched_pkg::DEFAULT_NUM_REQ,
    parameter int unsigned WIDTH_W = pulse_sched_pkg::DEFAULT_WIDTH_W
);

    logic [NUM_REQ-1:0]         in_req;
    logic [NUM_REQ*WIDTH_W-1:0] in_width;
    logic [NUM_REQ-1:0]         out_grant;
    logic [NUM_REQ-1:0]         out_done;
    logic                       out_error;
    logic                       out_set;
    logic [WIDTH_W-1:0]         out_value;
    logic                       in_ack;
    logic                       out_trigger;
    logic                       in_pulse;

    // Requesters plus extender side.
    modport master (
        output in_req, in_width, in_ack, in_pulse,
        input  out_grant, out_done, out_error, out_set, out_value, out_trigger
    );

    // Scheduler side.
    modport slave (
        input  in_req, in_width, in_ack, in_pulse,
        output out_grant, out_done, out_error, out_set, out_value, out_trigger
    );

endinterface

// File: rtl/pulse_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, with wrap-around.
module rr_arbiter
    import pulse_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    int unsigned      sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = 0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = 32'(ptr) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = PTR_W'(sum);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Round-robin scheduler that programs and fires an external pulse extender per request.
// Optional watchdog on the wait states: define PULSE_SCHED_TIMEOUT_EN.
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned WIDTH_W = DEFAULT_WIDTH_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input logic              in_clock,
    input logic              in_reset,
    pulse_scheduler_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   next_ptr;
    logic [WIDTH_W-1:0] last_width;
    logic [NUM_REQ-1:0] winner;
    logic [PTR_W-1:0]   winner_idx;
    logic [WIDTH_W-1:0] winner_width;
    logic               wd_abort;

    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               error_q;
    logic               set_q;
    logic [WIDTH_W-1:0] value_q;
    logic               trigger_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (bus.in_req),
        .ptr    (rr_ptr),
        .winner (winner)
    );

    always_comb begin
        winner_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                winner_idx = PTR_W'(i);
            end
        end
        winner_width = bus.in_width[winner_idx*WIDTH_W +: WIDTH_W];
        if (winner_width == '0) begin
            winner_width = WIDTH_W'(1);
        end
        next_ptr = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end

`ifdef PULSE_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            waiting;
    logic            leaving;

    always_comb begin
        waiting = 1'b0;
        leaving = 1'b0;
        case (state)
            ST_PROGRAM:   begin waiting = 1'b1; leaving = bus.in_ack;   end
            ST_WAIT_HIGH: begin waiting = 1'b1; leaving = bus.in_pulse;  end
            ST_WAIT_LOW:  begin waiting = 1'b1; leaving = !bus.in_pulse; end
            default:      begin waiting = 1'b0; leaving = 1'b0;          end
        endcase
    end

    // Counter restarts on every state change, so each wait state gets a full TIMEOUT budget.
    assign wd_abort = waiting && !leaving && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge in_clock) begin
        if (in_reset || !waiting || leaving || wd_abort) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_abort = 1'b0;
`endif

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            error_q    <= 1'b0;
            set_q      <= 1'b0;
            value_q    <= '0;
            trigger_q  <= 1'b0;
            rr_ptr     <= '0;
            owner      <= '0;
            last_width <= WIDTH_W'(1);
        end else begin
            done_q    <= '0;
            error_q   <= 1'b0;
            trigger_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|bus.in_req) begin
                        grant_q <= winner;
                        owner   <= winner_idx;
                        value_q <= winner_width;
                        if (winner_width == last_width) begin
                            state <= ST_FIRE;
                        end else begin
                            set_q <= 1'b1;
                            state <= ST_PROGRAM;
                        end
                    end
                end
                ST_PROGRAM: begin
                    if (bus.in_ack) begin
                        set_q      <= 1'b0;
                        last_width <= value_q;
                        state      <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    trigger_q <= 1'b1;
                    state     <= ST_WAIT_HIGH;
                end
                ST_WAIT_HIGH: begin
                    if (bus.in_pulse) begin
                        state <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!bus.in_pulse) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= grant_q;
                    grant_q <= '0;
                    rr_ptr  <= next_ptr;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // Watchdog abort overrides whatever the wait state scheduled above.
            if (wd_abort) begin
                error_q    <= 1'b1;
                set_q      <= 1'b0;
                grant_q    <= '0;
                last_width <= '0;
                rr_ptr     <= next_ptr;
                state      <= ST_IDLE;
            end
        end
    end

    assign bus.out_grant   = grant_q;
    assign bus.out_done    = done_q;
    assign bus.out_error   = error_q;
    assign bus.out_set     = set_q;
    assign bus.out_value   = value_q;
    assign bus.out_trigger = trigger_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Randomized bench for pulse_scheduler; the bench plays both the requesters and the pulse extender.
module tb_pulse_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 255;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;
    int m_last   = 1;

    pulse_scheduler_if #(.NUM_REQ(N), .WIDTH_W(W)) bus ();

    pulse_scheduler #(.NUM_REQ(N), .WIDTH_W(W), .TIMEOUT(TO)) dut (
        .in_clock (clk),
        .in_reset (rst),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL time_limit: got no finish expected finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference: first requested index at/after the round-robin pointer.
    function automatic int model_winner(input logic [N-1:0] mask);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    function automatic int model_width(input logic [N*W-1:0] widths, input int idx);
        logic [W-1:0] s;
        s = widths[idx*W +: W];
        return (s == 0) ? 1 : int'(s);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_grant"},   32'(bus.out_grant),   32'(0));
        check_val({tag, "_done"},    32'(bus.out_done),    32'(0));
        check_val({tag, "_error"},   32'(bus.out_error),   32'(0));
        check_val({tag, "_set"},     32'(bus.out_set),     32'(0));
        check_val({tag, "_trigger"}, 32'(bus.out_trigger), 32'(0));
        check_val({tag, "_value"},   32'(bus.out_value),   32'(0));
    endtask

    task automatic do_txn(input logic [N-1:0] mask, input logic [N*W-1:0] widths,
                          input int ack_dly, input int hi_dly, input int plen,
                          input bit perturb, input bit rst_in_low);
        int idx;
        int w;
        bit prog;
        logic [31:0] exp_g;
        idx   = model_winner(mask);
        w     = model_width(widths, idx);
        prog  = (w != m_last);
        exp_g = 32'(1) << idx;

        bus.in_req   = mask;
        bus.in_width = widths;
        step();
        check_val("grant", 32'(bus.out_grant), exp_g);
        check_val("set_at_grant", 32'(bus.out_set), 32'(prog));
        if (prog) check_val("value", 32'(bus.out_value), 32'(w));
        if (perturb) begin
            bus.in_req   = N'($urandom);
            bus.in_width = (N*W)'($urandom);
        end

        if (prog) begin
            for (int c = 0; c < ack_dly; c++) begin
                step();
                check_val("set_held", 32'(bus.out_set), 32'(1));
                check_val("trig_in_prog", 32'(bus.out_trigger), 32'(0));
            end
            bus.in_ack = 1'b1;
            step();
            bus.in_ack = 1'b0;
            check_val("set_clear", 32'(bus.out_set), 32'(0));
            check_val("trig_early", 32'(bus.out_trigger), 32'(0));
        end

        step();
        check_val("trigger", 32'(bus.out_trigger), 32'(1));
        step();
        check_val("trigger_one", 32'(bus.out_trigger), 32'(0));
        for (int c = 0; c < hi_dly; c++) begin
            step();
            check_val("grant_hold_hi", 32'(bus.out_grant), exp_g);
        end
        bus.in_pulse = 1'b1;
        for (int c = 0; c < plen; c++) begin
            step();
            check_val("grant_hold_lo", 32'(bus.out_grant), exp_g);
            check_val("done_in_pulse", 32'(bus.out_done), 32'(0));
        end

        if (rst_in_low) begin
            rst = 1'b1;
            step();
            check_idle_outputs("rst_mid");
            rst          = 1'b0;
            bus.in_req   = '0;
            bus.in_pulse = 1'b0;
            m_ptr        = 0;
            m_last       = 1;
            for (int c = 0; c < 3; c++) begin
                step();
                check_val("post_rst_done", 32'(bus.out_done), 32'(0));
                check_val("post_rst_error", 32'(bus.out_error), 32'(0));
            end
            return;
        end

        bus.in_pulse = 1'b0;
        step();
        check_val("done_early", 32'(bus.out_done), 32'(0));
        check_val("grant_before_done", 32'(bus.out_grant), exp_g);
        step();
        check_val("done", 32'(bus.out_done), exp_g);
        check_val("grant_clear", 32'(bus.out_grant), 32'(0));
        check_val("no_error", 32'(bus.out_error), 32'(0));
        bus.in_req = '0;
        m_ptr = (idx + 1) % N;
        if (prog) m_last = w;
    endtask

`ifdef PULSE_SCHED_TIMEOUT_EN
    task automatic watchdog_txn(input logic [N-1:0] mask, input logic [N*W-1:0] widths);
        int idx;
        int hit;
        idx = model_winner(mask);
        bus.in_req   = mask;
        bus.in_width = widths;
        step();
        check_val("wd_grant", 32'(bus.out_grant), 32'(1) << idx);
        check_val("wd_set", 32'(bus.out_set), 32'(1));
        hit = -1;
        for (int c = 1; c <= TO + 40 && hit < 0; c++) begin
            step();
            if (bus.out_error) hit = c;
            else check_val("wd_no_done", 32'(bus.out_done), 32'(0));
        end
        check_val("wd_cycle", 32'(hit), 32'(TO));
        check_val("wd_grant_clear", 32'(bus.out_grant), 32'(0));
        check_val("wd_set_clear", 32'(bus.out_set), 32'(0));
        check_val("wd_done", 32'(bus.out_done), 32'(0));
        bus.in_req = '0;
        step();
        check_val("wd_error_one", 32'(bus.out_error), 32'(0));
        check_val("wd_done_after", 32'(bus.out_done), 32'(0));
        m_ptr  = (idx + 1) % N;
        m_last = 0;
    endtask
`endif

    initial begin
        logic [N-1:0]   m;
        logic [N*W-1:0] wv;

        rst          = 1'b1;
        bus.in_req   = '0;
        bus.in_width = '0;
        bus.in_ack   = 1'b0;
        bus.in_pulse = 1'b0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();
        check_idle_outputs("idle");

        // Single request with programming, then the same width from the cache.
        do_txn(4'b0001, 32'h0000_0005, 2, 0, 3, 1'b0, 1'b0);
        do_txn(4'b0001, 32'h0000_0005, 0, 0, 1, 1'b0, 1'b0);
        // Width 1 programmed, then width 0 promoted to 1 fires directly.
        do_txn(4'b0010, 32'h0000_0100, 1, 1, 2, 1'b0, 1'b0);
        do_txn(4'b0100, 32'h0000_0000, 0, 0, 1, 1'b0, 1'b0);

        // Reset while waiting for the pulse to fall.
        do_txn(4'b1000, 32'h0700_0000, 1, 1, 2, 1'b0, 1'b1);

        // Contention from pointer 0 with widths that all hit the reset cache value.
        for (int t = 0; t < 5; t++) begin
            do_txn(4'b1111, 32'h0100_0100, 0, 0, 1, 1'b0, 1'b0);
        end

        for (int t = 0; t < 30; t++) begin
            do m = N'($urandom); while (m == '0);
            wv = '0;
            for (int j = 0; j < N; j++) wv[j*W +: W] = W'($urandom_range(0, 3));
            do_txn(m, wv, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef PULSE_SCHED_TIMEOUT_EN
        watchdog_txn(4'b0001, 32'h0000_0009);
        do_txn(4'b0010, 32'h0000_0900, 1, 0, 1, 1'b0, 1'b0);
`else
        do_txn(4'b0001, 32'h0000_0009, 300, 0, 1, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
